// File: rtl/ps2_keymatrix.sv
// PS/2 keyboard receiver and scancode decoder that maintains the 80-bit active-low
// CPC key matrix. A registered external ROM maps each scancode to a matrix index.
module ps2_keymatrix #(
  parameter int TIMEOUT_CYCLES = 16000,
  parameter int FILTER_LEN     = 4
) (
  input  logic        clk_i,
  input  logic        nreset_i,
  input  logic        ps2_clk_i,
  input  logic        ps2_dat_i,
  output logic [8:0]  map_addr_o,
  input  logic [7:0]  map_data_i,
  output logic [79:0] keyboard_o,
  output logic [7:0]  scancode_o,
  output logic        scancode_valid_o,
  output logic        frame_err_o
);

  // state     | meaning
  // RX_IDLE   | waiting for a start bit
  // RX_DATA   | shifting 8 data bits, LSB first
  // RX_PARITY | capturing the odd-parity bit
  // RX_STOP   | checking the stop bit and parity
  // DEC_IDLE  | waiting for a received byte
  // DEC_LOOKUP| ROM address presented, data pending
  // DEC_APPLY | ROM data valid, matrix update
  localparam logic [1:0] RX_IDLE    = 2'd0;
  localparam logic [1:0] RX_DATA    = 2'd1;
  localparam logic [1:0] RX_PARITY  = 2'd2;
  localparam logic [1:0] RX_STOP    = 2'd3;
  localparam logic [1:0] DEC_IDLE   = 2'd0;
  localparam logic [1:0] DEC_LOOKUP = 2'd1;
  localparam logic [1:0] DEC_APPLY  = 2'd2;

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int FL_W = $clog2(FILTER_LEN + 1);

  logic            clk_meta_q, clk_sync_q, dat_meta_q, dat_sync_q;
  logic            filt_lvl_q, filt_lvl_d;
  logic [FL_W-1:0] filt_cnt_q, filt_cnt_d;
  logic            clk_fall;

  logic [1:0]      rx_state_q, rx_state_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            par_q, par_d;
  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic [7:0]      scancode_q, scancode_d;
  logic            sc_valid_q, sc_valid_d;
  logic            frame_err_q, frame_err_d;
  logic            rx_err;

  logic [1:0]      dec_state_q, dec_state_d;
  logic            ext_q, ext_d, brk_q, brk_d;
  logic [2:0]      skip_q, skip_d;
  logic [8:0]      map_addr_q, map_addr_d;
  logic [79:0]     kbd_q, kbd_d;
  logic            dec_drop;

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
    end else begin
      clk_meta_q <= ps2_clk_i;
      clk_sync_q <= clk_meta_q;
      dat_meta_q <= ps2_dat_i;
      dat_sync_q <= dat_meta_q;
    end
  end

  // A level change is taken on the FILTER_LEN-th consecutive differing sample.
  always_comb begin
    filt_lvl_d = filt_lvl_q;
    filt_cnt_d = '0;
    clk_fall   = 1'b0;
    if (clk_sync_q != filt_lvl_q) begin
      if (filt_cnt_q == FL_W'(FILTER_LEN - 1)) begin
        filt_lvl_d = clk_sync_q;
        clk_fall   = filt_lvl_q;
      end else begin
        filt_cnt_d = filt_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    wd_cnt_d   = wd_cnt_q;
    scancode_d = scancode_q;
    sc_valid_d = 1'b0;
    rx_err     = 1'b0;

    if (clk_fall) begin
      wd_cnt_d = WD_W'(TIMEOUT_CYCLES - 1);
    end else if (rx_state_q != RX_IDLE && wd_cnt_q != '0) begin
      wd_cnt_d = wd_cnt_q - 1'b1;
    end

    case (rx_state_q)
      RX_IDLE: begin
        if (clk_fall && !dat_sync_q) begin
          rx_state_d = RX_DATA;
          bit_cnt_d  = '0;
        end
      end
      RX_DATA: begin
        if (clk_fall) begin
          shift_d   = {dat_sync_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) rx_state_d = RX_PARITY;
        end
      end
      RX_PARITY: begin
        if (clk_fall) begin
          par_d      = dat_sync_q;
          rx_state_d = RX_STOP;
        end
      end
      default: begin
        if (clk_fall) begin
          rx_state_d = RX_IDLE;
          if (dat_sync_q && (^{shift_q, par_q})) begin
            scancode_d = shift_q;
            sc_valid_d = 1'b1;
          end else begin
            rx_err = 1'b1;
          end
        end
      end
    endcase

    if (!clk_fall && rx_state_q != RX_IDLE && wd_cnt_q == '0) begin
      rx_state_d = RX_IDLE;
      rx_err     = 1'b1;
    end
  end

  assign dec_drop    = sc_valid_q && (dec_state_q != DEC_IDLE);
  assign frame_err_d = rx_err | dec_drop;

  always_comb begin
    dec_state_d = dec_state_q;
    ext_d       = ext_q;
    brk_d       = brk_q;
    skip_d      = skip_q;
    map_addr_d  = map_addr_q;
    kbd_d       = kbd_q;
    case (dec_state_q)
      DEC_IDLE: begin
        if (sc_valid_q) begin
          if (skip_q != 3'd0) begin
            skip_d = skip_q - 1'b1;
          end else begin
            case (scancode_q)
              8'hE1: begin skip_d = 3'd7; ext_d = 1'b0; brk_d = 1'b0; end
              8'hF0: brk_d = 1'b1;
              8'hE0: ext_d = 1'b1;
              8'hAA: begin kbd_d = '1; ext_d = 1'b0; brk_d = 1'b0; end
              8'h00, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF: begin
                ext_d = 1'b0;
                brk_d = 1'b0;
              end
              default: begin
                map_addr_d  = {ext_q, scancode_q};
                dec_state_d = DEC_LOOKUP;
              end
            endcase
          end
        end
      end
      DEC_LOOKUP: dec_state_d = DEC_APPLY;
      default: begin
        if (map_data_i[7]) begin
          for (int i = 0; i < 80; i++) begin
            if (map_data_i[6:0] == 7'(i)) kbd_d[i] = brk_q;
          end
        end
        ext_d       = 1'b0;
        brk_d       = 1'b0;
        dec_state_d = DEC_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      filt_lvl_q  <= 1'b1;
      filt_cnt_q  <= '0;
      rx_state_q  <= RX_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      wd_cnt_q    <= WD_W'(TIMEOUT_CYCLES - 1);
      scancode_q  <= '0;
      sc_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      dec_state_q <= DEC_IDLE;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      skip_q      <= '0;
      map_addr_q  <= '0;
      kbd_q       <= '1;
    end else begin
      filt_lvl_q  <= filt_lvl_d;
      filt_cnt_q  <= filt_cnt_d;
      rx_state_q  <= rx_state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      wd_cnt_q    <= wd_cnt_d;
      scancode_q  <= scancode_d;
      sc_valid_q  <= sc_valid_d;
      frame_err_q <= frame_err_d;
      dec_state_q <= dec_state_d;
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      skip_q      <= skip_d;
      map_addr_q  <= map_addr_d;
      kbd_q       <= kbd_d;
    end
  end

  assign map_addr_o       = map_addr_q;
  assign keyboard_o       = kbd_q;
  assign scancode_o       = scancode_q;
  assign scancode_valid_o = sc_valid_q;
  assign frame_err_o      = frame_err_q;

endmodule

// File: tb/tb_ps2_keymatrix.sv
// Bench for ps2_keymatrix: bit-banged PS/2 frames, a registered mapping ROM model,
// a scancode scoreboard and a key-matrix latency monitor.
module tb_ps2_keymatrix;

  logic        clk_i = 1'b0;
  logic        nreset_i = 1'b0;
  logic        ps2_clk_i = 1'b1;
  logic        ps2_dat_i = 1'b1;
  logic [8:0]  map_addr_o;
  logic [7:0]  map_data_i = 8'h00;
  logic [79:0] keyboard_o;
  logic [7:0]  scancode_o;
  logic        scancode_valid_o;
  logic        frame_err_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  exp_q[$];
  int          cyc = 0;
  int          last_valid_cyc = -100;
  logic [7:0]  last_byte = 8'h00;
  logic [79:0] kbd_prev = '1;
  int          err_seen = 0;

  ps2_keymatrix dut (
    .clk_i            (clk_i),
    .nreset_i         (nreset_i),
    .ps2_clk_i        (ps2_clk_i),
    .ps2_dat_i        (ps2_dat_i),
    .map_addr_o       (map_addr_o),
    .map_data_i       (map_data_i),
    .keyboard_o       (keyboard_o),
    .scancode_o       (scancode_o),
    .scancode_valid_o (scancode_valid_o),
    .frame_err_o      (frame_err_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [7:0] rom_lookup(input logic [8:0] a);
    case (a)
      9'h01C:  return 8'h80 | 8'd69;
      9'h175:  return 8'h80 | 8'd0;
      9'h01B:  return 8'h80 | 8'd60;
      9'h023:  return 8'h80 | 8'd90;
      9'h015:  return 8'h80 | 8'd5;
      9'h014:  return 8'h80 | 8'd10;
      9'h077:  return 8'h80 | 8'd11;
      default: return 8'h00;
    endcase
  endfunction

  always @(posedge clk_i) map_data_i <= rom_lookup(map_addr_o);
  always @(posedge clk_i) cyc++;

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard pop and matrix-change latency tracking.
  always @(negedge clk_i) begin
    if (nreset_i) begin
      if (scancode_valid_o) begin
        last_valid_cyc = cyc;
        if (exp_q.size() == 0) begin
          check("sb_unexpected", 80'(exp_q.size()), 80'd1);
          last_byte = scancode_o;
        end else begin
          last_byte = exp_q.pop_front();
          check("scancode", 80'(scancode_o), 80'(last_byte));
        end
      end
      if (frame_err_o) err_seen++;
      if (keyboard_o !== kbd_prev) begin
        check("kbd_latency", 80'(cyc - last_valid_cyc), (last_byte == 8'hAA) ? 80'd1 : 80'd3);
        kbd_prev = keyboard_o;
      end
    end
  end

  task automatic ps2_bit(input logic b);
    ps2_dat_i = b;
    repeat (10) @(posedge clk_i);
    ps2_clk_i = 1'b0;
    repeat (20) @(posedge clk_i);
    ps2_clk_i = 1'b1;
    repeat (10) @(posedge clk_i);
  endtask

  task automatic send_raw(input logic [7:0] d, input logic par_flip, input logic stop_b);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(d[i]);
    ps2_bit((~^d) ^ par_flip);
    ps2_bit(stop_b);
    ps2_dat_i = 1'b1;
    repeat (20) @(posedge clk_i);
  endtask

  task automatic send(input logic [7:0] d);
    exp_q.push_back(d);
    send_raw(d, 1'b0, 1'b1);
  endtask

  task automatic settle();
    repeat (10) @(posedge clk_i);
    @(negedge clk_i);
    check("sb_drain", 80'(exp_q.size()), 80'd0);
  endtask

  initial begin
    #5ms;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    logic [79:0] kbd_exp;
    logic [7:0]  pause_seq [7];
    int          e0;
    kbd_exp = '1;
    pause_seq = '{8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

    repeat (5) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_kbd", keyboard_o, kbd_exp);
    check("rst_scancode", 80'(scancode_o), 80'h00);
    check("rst_valid", 80'(scancode_valid_o), 80'd0);
    check("rst_err", 80'(frame_err_o), 80'd0);
    check("rst_addr", 80'(map_addr_o), 80'd0);
    nreset_i = 1'b1;
    repeat (5) @(posedge clk_i);

    send(8'h1C); settle();
    kbd_exp[69] = 1'b0;
    check("press_1c", keyboard_o, kbd_exp);
    check("addr_1c", 80'(map_addr_o), 80'h01C);
    send(8'hF0); send(8'h1C); settle();
    kbd_exp[69] = 1'b1;
    check("release_1c", keyboard_o, kbd_exp);

    send(8'hE0); send(8'h75); settle();
    kbd_exp[0] = 1'b0;
    check("addr_e075", 80'(map_addr_o), 80'h175);
    check("press_e075", keyboard_o, kbd_exp);
    send(8'hE0); send(8'hF0); send(8'h75); settle();
    kbd_exp[0] = 1'b1;
    check("release_e075", keyboard_o, kbd_exp);
    check("addr_e0f075", 80'(map_addr_o), 80'h175);
    send(8'h1C); settle();
    kbd_exp[69] = 1'b0;
    check("flags_clear_addr", 80'(map_addr_o), 80'h01C);
    check("flags_clear_kbd", keyboard_o, kbd_exp);
    send(8'hF0); send(8'h1C); settle();
    kbd_exp[69] = 1'b1;
    check("release_again", keyboard_o, kbd_exp);

    e0 = err_seen;
    send_raw(8'h1C, 1'b1, 1'b1); settle();
    check("err_parity", 80'(err_seen - e0), 80'd1);
    check("kbd_after_parity", keyboard_o, kbd_exp);
    e0 = err_seen;
    send_raw(8'h1C, 1'b0, 1'b0); settle();
    check("err_stop", 80'(err_seen - e0), 80'd1);
    check("kbd_after_stop", keyboard_o, kbd_exp);

    e0 = err_seen;
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(i[0] ? 1'b0 : 1'b0);
    ps2_dat_i = 1'b1;
    repeat (16100) @(posedge clk_i);
    @(negedge clk_i);
    check("err_timeout", 80'(err_seen - e0), 80'd1);
    send(8'h1C); settle();
    kbd_exp[69] = 1'b0;
    check("press_after_timeout", keyboard_o, kbd_exp);
    send(8'hF0); send(8'h1C); settle();
    kbd_exp[69] = 1'b1;
    check("release_after_timeout", keyboard_o, kbd_exp);

    send(8'h1C); send(8'h1B); settle();
    kbd_exp[69] = 1'b0;
    kbd_exp[60] = 1'b0;
    check("multi_press", keyboard_o, kbd_exp);
    send(8'h1C); settle();
    check("typematic", keyboard_o, kbd_exp);
    send(8'h23); settle();
    check("index_out_of_range", keyboard_o, kbd_exp);
    send(8'hF0); send(8'h15); settle();
    check("release_unpressed", keyboard_o, kbd_exp);
    send(8'hAA); settle();
    kbd_exp = '1;
    check("self_test_clear", keyboard_o, kbd_exp);

    send(8'h1C); settle();
    kbd_exp[69] = 1'b0;
    send(8'hE1);
    foreach (pause_seq[i]) send(pause_seq[i]);
    settle();
    check("pause_skipped", keyboard_o, kbd_exp);
    send(8'h1B); settle();
    kbd_exp[60] = 1'b0;
    check("after_pause", keyboard_o, kbd_exp);
    check("err_total", 80'(err_seen), 80'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
